// File: rtl/calc_disp_pkg.sv
// ---------------------------------------------------------------------------
// calc_disp_pkg
// Purpose : Types and constants shared by the calculator answer-display path
//           (binary-to-BCD converter and its add-3 nibble cell).
// Contents: state_t      - converter FSM states (IDLE, SHIFT, DONE)
//           bcd_digit_t  - one packed BCD digit
//           BLANK_CODE   - digit code the seven-segment encoder shows dark
//           MAX_VAL      - largest value that fits in four decimal digits
//           blank_leading() - turns leading zero digits into the blank code
// ---------------------------------------------------------------------------
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_CODE = 4'hF;
    localparam int         MAX_VAL    = 9999;

    // Blank every zero digit above the most significant nonzero one.
    // The units digit is never blanked, so a value of zero still shows "0".
    function automatic logic [15:0] blank_leading(input logic [15:0] digits,
                                                  input bcd_digit_t blank);
        logic [15:0] res;
        res = digits;
        if (digits[15:12] == 4'd0) begin
            res[15:12] = blank;
            if (digits[11:8] == 4'd0) begin
                res[11:8] = blank;
                if (digits[7:4] == 4'd0) begin
                    res[7:4] = blank;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// ---------------------------------------------------------------------------
// bcd_add3_nibble
// Purpose : Shift-add-3 correction cell for one BCD digit. A digit of 5 or
//           more becomes >= 10 after the following left shift, so adding 3
//           first makes the shift carry correctly into the next digit.
//           Inputs 5..9 map to 8..12, so the result never leaves the nibble.
// Ports   : din  - BCD digit before correction
//           dout - corrected digit
// ---------------------------------------------------------------------------
module bcd_add3_nibble
    import calc_disp_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Purpose : Sequential binary-to-BCD converter for the calculator answer
//           path. Uses shift-add-3 (double dabble), one operand bit per
//           clock. The result is committed WIDTH+1 edges after the accepting
//           edge and is then held until the next accepted start, clr or reset.
// Ports   : Clk      - system clock, rising edge
//           Reset_n  - asynchronous active-low reset
//           start    - single-cycle request, accepted in IDLE or DONE only
//           operand  - unsigned binary value, sampled on the accepting edge
//           clr      - synchronous clear of result/ansrdy (ignored while busy)
//           busy     - conversion in progress
//           ansrdy   - digits valid
//           ovf      - last operand exceeded MAX_VAL (digits shown blank)
//           ans0/ans10/ans100/ans1000 - units/tens/hundreds/thousands digits
// Options : LEAD_ZERO_BLANK_EN - when defined, leading zero digits are
//           replaced by BLANK_CODE at commit time (units digit always shown).
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int         WIDTH      = 14,
    parameter int         MAX_VAL    = calc_disp_pkg::MAX_VAL,
    parameter logic [3:0] BLANK_CODE = calc_disp_pkg::BLANK_CODE
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic             clr,
    output logic             busy,
    output logic             ansrdy,
    output logic             ovf,
    output logic [3:0]       ans0,
    output logic [3:0]       ans10,
    output logic [3:0]       ans100,
    output logic [3:0]       ans1000
);

    import calc_disp_pkg::*;

    // iter counts 0..WIDTH: values below WIDTH are shift cycles, WIDTH is
    // the extra commit cycle that gives the fixed WIDTH+1 latency.
    localparam int ITER_W = $clog2(WIDTH + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH);
    localparam logic [15:0]       ALL_BLANK = {4{BLANK_CODE}};

    state_t            state_q,    state_d;
    logic [WIDTH-1:0]  shift_q,    shift_d;
    logic [15:0]       acc_q,      acc_d;
    logic [ITER_W-1:0] iter_q,     iter_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              busy_q,     busy_d;
    logic              ansrdy_q,   ansrdy_d;
    logic              ovf_q,      ovf_d;
    logic [15:0]       ans_q,      ans_d;

    logic [15:0]       acc_adj;
    logic [31:0]       operand_ext;

    assign operand_ext = 32'(operand);

    // One add-3 correction cell per BCD digit of the accumulator.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_add3
            bcd_add3_nibble u_add3 (
                .din  (acc_q[gi*4 +: 4]),
                .dout (acc_adj[gi*4 +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        ansrdy_d   = ansrdy_q;
        ovf_d      = ovf_q;
        ans_d      = ans_q;

        case (state_q)
            IDLE, DONE: begin
                // start has priority over clr on the same edge; digits keep
                // their old values until the commit, only ansrdy drops.
                if (start) begin
                    shift_d    = operand;
                    acc_d      = 16'd0;
                    iter_d     = '0;
                    ovf_pend_d = (operand_ext > 32'(MAX_VAL));
                    ansrdy_d   = 1'b0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end else if (clr) begin
                    ansrdy_d = 1'b0;
                    ovf_d    = 1'b0;
                    ans_d    = ALL_BLANK;
                end
            end

            SHIFT: begin
                if (iter_q == ITER_LAST) begin
                    // Commit edge: all WIDTH bits have been shifted in.
                    if (ovf_pend_q) begin
                        ovf_d = 1'b1;
                        ans_d = ALL_BLANK;
                    end else begin
`ifdef LEAD_ZERO_BLANK_EN
                        ans_d = blank_leading(acc_q, BLANK_CODE);
`else
                        ans_d = acc_q;
`endif
                    end
                    ansrdy_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    // Corrected accumulator and operand shift left as one word.
                    acc_d   = {acc_adj[14:0], shift_q[WIDTH-1]};
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    iter_d  = iter_q + ITER_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= 16'd0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            ansrdy_q   <= 1'b0;
            ovf_q      <= 1'b0;
            ans_q      <= ALL_BLANK;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            ansrdy_q   <= ansrdy_d;
            ovf_q      <= ovf_d;
            ans_q      <= ans_d;
        end
    end

    assign busy    = busy_q;
    assign ansrdy  = ansrdy_q;
    assign ovf     = ovf_q;
    assign ans0    = ans_q[3:0];
    assign ans10   = ans_q[7:4];
    assign ans100  = ans_q[11:8];
    assign ans1000 = ans_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. Expected digits are computed from
// the operand with decimal division and queued when a start is accepted;
// each committed result pops and compares the oldest entry. Honour
// LEAD_ZERO_BLANK_EN the same way as the design build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    localparam int WIDTH = 14;

    typedef struct packed {
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] operand = '0;
    logic             clr = 1'b0;
    logic             busy, ansrdy, ovf;
    logic [3:0]       ans0, ans10, ans100, ans1000;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [15:0] last_digits = 16'hFFFF;

    bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .operand (operand),
        .clr     (clr),
        .busy    (busy),
        .ansrdy  (ansrdy),
        .ovf     (ovf),
        .ans0    (ans0),
        .ans10   (ans10),
        .ans100  (ans100),
        .ans1000 (ans1000)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] digits_now();
        return {ans1000, ans100, ans10, ans0};
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        logic [3:0] d3, d2, d1, d0;
        if (v > 9999) begin
            e.dig = 16'hFFFF;
            e.ovf = 1'b1;
        end else begin
            d3 = 4'((v / 1000) % 10);
            d2 = 4'((v / 100) % 10);
            d1 = 4'((v / 10) % 10);
            d0 = 4'(v % 10);
`ifdef LEAD_ZERO_BLANK_EN
            if (v < 1000) d3 = 4'hF;
            if (v < 100)  d2 = 4'hF;
            if (v < 10)   d1 = 4'hF;
`endif
            e.dig = {d3, d2, d1, d0};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive an accepted start (optionally with clr) and check the
    // immediate effects on the accepting edge.
    task automatic issue_start(input int val, input bit with_clr);
        operand = WIDTH'(val);
        start   = 1'b1;
        clr     = with_clr;
        @(posedge Clk);
        #1;
        start = 1'b0;
        clr   = 1'b0;
        exp_q.push_back(model(val));
        $display("start operand=%0d clr=%0d", val, with_clr);
        chk("accept_ansrdy", {31'd0, ansrdy}, 32'd0);
        chk("accept_busy",   {31'd0, busy},   32'd1);
        chk("accept_ovf",    {31'd0, ovf},    32'd0);
        chk("accept_hold",   {16'd0, digits_now()}, {16'd0, last_digits});
    endtask

    // Wait (bounded) for the commit, optionally pulsing start/clr at cycle
    // inj_at of the conversion, then compare against the scoreboard.
    task automatic wait_result(input int inj_at, input bit inj_start,
                               input bit inj_clr, input int inj_val);
        int   n;
        bit   done;
        exp_t e;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (n == inj_at) begin
                start   = inj_start;
                clr     = inj_clr;
                operand = WIDTH'(inj_val);
            end
            @(posedge Clk);
            #1;
            start = 1'b0;
            clr   = 1'b0;
            n++;
            if (ansrdy) begin
                done = 1'b1;
            end else if (n == 14) begin
                chk("busy_mid", {31'd0, busy}, 32'd1);
            end
        end
        chk("latency", 32'(n), 32'd15);
        chk("ansrdy_set", {31'd0, ansrdy}, 32'd1);
        chk("busy_clear", {31'd0, busy}, 32'd0);
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("digits", {16'd0, digits_now()}, {16'd0, e.dig});
            chk("ovf",    {31'd0, ovf},          {31'd0, e.ovf});
            last_digits = e.dig;
            $display("result digits=%04h ovf=%0d expected=%04h/%0d cycles=%0d",
                     digits_now(), ovf, e.dig, e.ovf, n);
        end
    endtask

    initial begin
        exp_t dropped;

        // Reset
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        $display("reset released");
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_ansrdy", {31'd0, ansrdy}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf},    32'd0);
        chk("rst_digits", {16'd0, digits_now()}, 32'h0000FFFF);

        // Plain conversions, including the largest legal value and zero
        issue_start(1234, 1'b0); wait_result(-1, 1'b0, 1'b0, 0);
        issue_start(9999, 1'b0); wait_result(-1, 1'b0, 1'b0, 0);
        issue_start(0,    1'b0); wait_result(-1, 1'b0, 1'b0, 0);

        // Overflow, then recovery
        issue_start(10000, 1'b0); wait_result(-1, 1'b0, 1'b0, 0);
        issue_start(7,     1'b0); wait_result(-1, 1'b0, 1'b0, 0);

        // Start while busy is ignored
        issue_start(55, 1'b0); wait_result(5, 1'b1, 1'b0, 99);

        // clr while busy is ignored
        issue_start(77, 1'b0); wait_result(3, 1'b0, 1'b1, 0);

        // Reset in the middle of a conversion
        issue_start(500, 1'b0);
        repeat (6) begin
            @(posedge Clk);
            #1;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        $display("async reset mid-conversion");
        chk("midrst_busy",   {31'd0, busy},   32'd0);
        chk("midrst_ansrdy", {31'd0, ansrdy}, 32'd0);
        chk("midrst_ovf",    {31'd0, ovf},    32'd0);
        chk("midrst_digits", {16'd0, digits_now()}, 32'h0000FFFF);
        dropped = exp_q.pop_back();
        last_digits = 16'hFFFF;
        #2;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        issue_start(321, 1'b0); wait_result(-1, 1'b0, 1'b0, 0);

        // clr in DONE
        clr = 1'b1;
        @(posedge Clk);
        #1;
        clr = 1'b0;
        $display("clr in DONE");
        chk("clr_ansrdy", {31'd0, ansrdy}, 32'd0);
        chk("clr_digits", {16'd0, digits_now()}, 32'h0000FFFF);
        last_digits = 16'hFFFF;
        repeat (2) @(posedge Clk);
        #1;
        chk("clr_hold", {16'd0, digits_now()}, 32'h0000FFFF);

        // clr and start together: start wins
        issue_start(8, 1'b1); wait_result(-1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
